// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed access latency and byte-enabled stores
//
// Purpose: accepts one load/store request at a time over a valid/ready channel,
// waits LATENCY cycles, performs the access on an internal word array and
// returns read data / completion over a valid/ready response channel.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   req_valid   request present            req_ready   responder idle, can accept
//   req_write   1 = store, 0 = load        req_addr    byte address
//   req_wdata   store data                 req_be      store byte enables (be[0] -> bits 7:0)
//   resp_valid  response present           resp_ready  CPU accepts response
//   resp_rdata  load data (0 for stores and errors)
//   resp_err    misaligned or out-of-range access

module dmem_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH_W  = 32'(MEM_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Zero at power-up only; reset deliberately leaves the contents alone.
    logic [31:0] mem_q [MEM_DEPTH] = '{default: 32'h0};

    logic [AW-1:0] word_idx;
    logic          acc_err;
    logic          do_access;
    logic          do_store;

    assign word_idx  = addr_q[AW+1:2];
    assign acc_err   = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH_W);
    assign do_access = (state_q == S_BUSY) && (cnt_q == 4'd0);
    // Gated by rst so a reset on the access edge aborts a pending store.
    assign do_store  = do_access && wr_q && !acc_err && !rst;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (acc_err) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else if (wr_q) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = mem_q[word_idx];
                        err_d   = 1'b0;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 2, 1 and 4 instances)

module tb_dmem_responder;

    localparam int DEPTH = 256;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    logic [31:0] mem_m [3][DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        dmem_responder #(
            .MEM_DEPTH(DEPTH),
            .LATENCY  ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a plain word array, byte lanes written by be, errors leave it untouched.
    task automatic model_access(input int k, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rdata, output logic err);
        int unsigned w;
        w     = addr / 4;
        rdata = 32'h0;
        err   = 1'b0;
        if ((addr % 4) != 0 || w >= DEPTH) begin
            err = 1'b1;
        end else if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_m[k][w][8*i +: 8] = wdata[8*i +: 8];
        end else begin
            rdata = mem_m[k][w];
        end
    endtask

    task automatic chk_reset_outputs(input int k, input string tag);
        chk({tag, "_req_ready"},  32'(req_ready[k]),  32'h1);
        chk({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata[k],      32'h0);
        chk({tag, "_resp_err"},   32'(resp_err[k]),   32'h0);
    endtask

    // One full transaction: latency measured in edges after the acceptance edge,
    // response held with resp_ready low for `hold` cycles, then handshaken.
    task automatic do_txn(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          output logic [31:0] rdata, output logic err);
        int lat;
        bit seen;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[k]), 32'h1);
        req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr;
        req_wdata[k] = wdata; req_be[k] = be; resp_ready[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs to prove they were captured at acceptance.
        req_valid[k] = 1'b0; req_write[k] = ~wr; req_addr[k] = $urandom;
        req_wdata[k] = $urandom; req_be[k] = 4'($urandom);
        lat  = 0;
        seen = 0;
        while (!seen && lat <= 20) begin
            if (resp_valid[k]) seen = 1;
            else begin
                chk("req_ready_busy", 32'(req_ready[k]), 32'h0);
                @(negedge clk);
                lat++;
            end
        end
        chk("resp_timeout", 32'(seen), 32'h1);
        chk("latency", 32'(lat), 32'(lat_of(k)));
        rdata = resp_rdata[k];
        err   = resp_err[k];
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(resp_valid[k]), 32'h1);
            chk("hold_rdata", resp_rdata[k], rdata);
            chk("hold_err", 32'(resp_err[k]), 32'(err));
            chk("hold_req_ready", 32'(req_ready[k]), 32'h0);
            @(negedge clk);
        end
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        chk("post_hs_valid", 32'(resp_valid[k]), 32'h0);
        chk("post_hs_req_ready", 32'(req_ready[k]), 32'h1);
        chk("post_hs_rdata", resp_rdata[k], 32'h0);
        chk("post_hs_err", 32'(resp_err[k]), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          cyc;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 32'h0;
            req_wdata[k] = 32'h0; req_be[k] = 4'h0; resp_ready[k] = 1'b0;
            for (int w = 0; w < DEPTH; w++) mem_m[k][w] = 32'h0;
        end

        // Table of directed vectors for the LATENCY=2 instance (4*DEPTH = 0x400).
        tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 32'h11BB_33DD, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0013, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_03FC, 32'h5A5A_5A5A, 4'b1000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'b0000, 32'h5A00_0000, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_03FE, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b1, 32'h0000_0001, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 32'h0000_0404, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset_outputs(k, $sformatf("reset%0d", k));
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            do_txn(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, i % 3, rd, er);
            model_access(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, mrd, mer);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // Backpressure: five cycles of resp_ready low on a load.
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er);
        chk("bp_rdata", rd, 32'h11BB_33DD);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [3:0]  be;
            int          r;
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            r     = $urandom_range(0, 9);
            if (r < 7)       addr = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) addr = (32'(DEPTH) + 32'($urandom_range(0, 1000))) << 2;
            else             addr = 32'(DEPTH - 1) << 2;
            do_txn(0, wr, addr, wdata, be, $urandom_range(0, 3), rd, er);
            model_access(0, wr, addr, wdata, be, mrd, mer);
            chk($sformatf("rnd%0d_rdata", n), rd, mrd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(mer));
        end

        // LATENCY=1 instance: round trip.
        do_txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        chk("l1_store_err", 32'(er), 32'h0);
        do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 1, rd, er);
        chk("l1_load_rdata", rd, 32'hDEAD_BEEF);

        // LATENCY=4 instance: reset one cycle after accepting a store aborts it.
        do_txn(2, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, rd, er);
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h40;
        req_wdata[2] = 32'h55; req_be[2] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        chk_reset_outputs(2, "busy_rst");
        rst[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("busy_rst_no_resp", 32'(resp_valid[2]), 32'h0);
        end
        do_txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er);
        chk("busy_rst_load", rd, 32'h1234_5678);

        // Reset while a store response is pending: the write stays.
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h44;
        req_wdata[2] = 32'hCAFE_F00D; req_be[2] = 4'hF; resp_ready[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        cyc = 0;
        while (!resp_valid[2] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("resp_rst_reached", 32'(resp_valid[2]), 32'h1);
        rst[2] = 1'b1;
        @(negedge clk);
        chk_reset_outputs(2, "resp_rst");
        rst[2] = 1'b0;
        do_txn(2, 1'b0, 32'h44, 32'h0, 4'h0, 0, rd, er);
        chk("resp_rst_load", rd, 32'hCAFE_F00D);

        // Reset and req_valid on the same edge: nothing is accepted.
        @(negedge clk);
        rst[2] = 1'b1; req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 32'h40;
        @(negedge clk);
        rst[2] = 1'b0; req_valid[2] = 1'b0;
        chk("rst_vs_req_ready", 32'(req_ready[2]), 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_vs_req_no_resp", 32'(resp_valid[2]), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port.
- The CPU's pipeline issues load/store requests; this block accepts them over a valid/ready request channel, models a fixed multi-cycle access latency, and returns read data or completion over a valid/ready response channel.
- It holds the word-addressed data array internally, supports byte-enabled stores, and flags misaligned or out-of-range accesses.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the array; legal word index is 0..MEM_DEPTH-1.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; be[0] maps to bits 7:0, be[3] to bits 31:24.
- resp_valid  output  1  response present.
- resp_ready  input  1  CPU accepts response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (sampled at a rising edge):
  - State goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Latency counter cleared; captured request cleared.
  - Memory array contents are not altered by reset. The array is zero-initialised at time 0 only.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is high at an edge, the request is accepted and write, addr, wdata and be are captured.
  - Counter loads LATENCY-1; next state is BUSY.
- BUSY:
  - req_ready=0.
  - While the counter is nonzero, it decrements.
  - At the edge where the counter is 0, the access is performed, the response registers are loaded, and the state moves to RESP.
  - Result: resp_valid rises exactly LATENCY edges after the acceptance edge.
- Access, performed once per request at the BUSY->RESP edge:
  - Error condition: addr[1:0]!=0, or addr[31:2] >= MEM_DEPTH. On error, resp_err=1, resp_rdata=0, and the array is not modified.
  - Load: resp_rdata = array[addr[31:2]] (full word; be ignored); resp_err=0.
  - Store: each byte lane i with be[i]=1 is written from wdata; lanes with be[i]=0 are unchanged. be=0000 completes normally with no change. resp_rdata=0, resp_err=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the handshake.
  - At an edge with resp_ready=1: resp_valid->0, resp_rdata->0, resp_err->0, next state IDLE.
  - With resp_ready=0 the state holds indefinitely.
  - req_ready=0 in RESP, so consecutive requests are separated by at least one IDLE cycle. Minimum request-to-request period is LATENCY+2 cycles when resp_ready is held high.
- req_valid in BUSY or RESP is ignored and not queued. The request is not lost, because req_ready=0 tells the CPU to hold it.
- Reset mid-operation:
  - Reset in BUSY aborts the request; a pending store is never written.
  - Reset in RESP discards the response; a store already written remains written.
- Reset and req_valid at the same edge: reset wins; nothing is accepted.

Test Plan:
- Store/load round-trip: store addr 0x10, wdata 0xDEADBEEF, be 1111; then load 0x10 -> load response resp_rdata=0xDEADBEEF, resp_err=0.
- Latency (LATENCY=2 and LATENCY=1): load accepted at edge N -> resp_valid high after edge N+2 (respectively N+1), and never earlier.
- Partial store: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD, be 0101; load 0x20 -> 0x11BB33DD.
- Errors: load 0x13 -> resp_err=1, rdata=0. Store to byte address 4*MEM_DEPTH -> resp_err=1, and a later load of address 0 is unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable and req_ready=0 throughout; raise resp_ready -> IDLE on the next edge, req_ready=1.
- Reset mid-operation: store 0x55 to 0x40 with LATENCY=4; assert rst one cycle after acceptance -> outputs return to reset values, and a later load of 0x40 returns its prior value.
